// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU: combinational single-cycle ops plus
// iterative shift-add multiply and restoring divide behind valid/ready channels.
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] rem,
   output logic [7:0]       flags,
   output logic             busy
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [7:0] OP_ADD  = 8'h01;
   localparam logic [7:0] OP_SUB  = 8'h02;
   localparam logic [7:0] OP_MUL  = 8'h03;
   localparam logic [7:0] OP_DIV  = 8'h04;
   localparam logic [7:0] OP_REM  = 8'h05;
   localparam logic [7:0] OP_AND  = 8'h06;
   localparam logic [7:0] OP_OR   = 8'h07;
   localparam logic [7:0] OP_XOR  = 8'h08;
   localparam logic [7:0] OP_NAND = 8'h09;
   localparam logic [7:0] OP_NOR  = 8'h0A;
   localparam logic [7:0] OP_XNOR = 8'h0B;
   localparam logic [7:0] OP_NOT  = 8'h0C;
   localparam logic [7:0] OP_SHL  = 8'h0D;
   localparam logic [7:0] OP_SHR  = 8'h0E;
   localparam logic [7:0] OP_CMP  = 8'h0F;
   localparam logic [7:0] OP_MOV  = 8'h80;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [7:0]       r_op;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [SHW-1:0]   r_cnt;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_rem;
   logic [7:0]       r_flags;

   logic             w_accept;
   logic             w_is_mul;
   logic             w_is_div;
   logic             w_div_zero;

   function automatic logic [7:0] f_flags(input logic [WIDTH-1:0] res, input logic c,
                                          input logic v, input logic dz);
      return {1'b0, v, 1'b0, dz, ~^res, res[WIDTH-1], c, (res == '0)};
   endfunction

   assign w_is_mul   = (op == OP_MUL);
   assign w_is_div   = (op == OP_DIV) || (op == OP_REM);
   assign w_div_zero = (b == '0);
   assign w_accept   = in_valid & in_ready;

   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic [WIDTH:0]   w_shl;
   logic [WIDTH:0]   w_shr;
   logic [SHW-1:0]   w_amt;
   logic             w_lt;
   logic             w_gt;
   logic             w_eq;

   assign w_amt = b[SHW-1:0];
   assign w_add = {1'b0, a} + {1'b0, b};
   assign w_sub = {1'b0, a} - {1'b0, b};
   // The extra bit on each shifter catches the last bit shifted out.
   assign w_shl = {1'b0, a} << w_amt;
   assign w_shr = {a, 1'b0} >> w_amt;
   assign w_lt  = (a < b);
   assign w_gt  = (a > b);
   assign w_eq  = (a == b);

   logic [WIDTH-1:0] w_sc_result;
   logic [WIDTH-1:0] w_sc_rem;
   logic [7:0]       w_sc_flags;
   logic             w_sc_c;
   logic             w_sc_v;
   logic             w_sc_dz;
   logic             w_sc_legal;

   always_comb begin
      w_sc_result = '0;
      w_sc_rem    = '0;
      w_sc_c      = 1'b0;
      w_sc_v      = 1'b0;
      w_sc_dz     = 1'b0;
      w_sc_legal  = 1'b1;
      case (op)
         OP_ADD: begin
            w_sc_result = w_add[WIDTH-1:0];
            w_sc_c      = w_add[WIDTH];
            w_sc_v      = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            w_sc_result = w_sub[WIDTH-1:0];
            w_sc_c      = w_sub[WIDTH];
            w_sc_v      = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
         end
         OP_MUL: ;
         OP_DIV, OP_REM: begin
            // Only reached with b==0; non-zero divisors go through the FSM.
            w_sc_result = '1;
            w_sc_rem    = a;
            w_sc_dz     = 1'b1;
         end
         OP_AND:  w_sc_result = a & b;
         OP_OR:   w_sc_result = a | b;
         OP_XOR:  w_sc_result = a ^ b;
         OP_NAND: w_sc_result = ~(a & b);
         OP_NOR:  w_sc_result = ~(a | b);
         OP_XNOR: w_sc_result = ~(a ^ b);
         OP_NOT:  w_sc_result = ~a;
         OP_SHL: begin
            w_sc_result = w_shl[WIDTH-1:0];
            w_sc_c      = w_shl[WIDTH];
         end
         OP_SHR: begin
            w_sc_result = w_shr[WIDTH:1];
            w_sc_c      = w_shr[0];
         end
         OP_CMP:  w_sc_result = {{(WIDTH-3){1'b0}}, w_lt, w_gt, w_eq};
         OP_MOV:  w_sc_result = a;
         default: w_sc_legal = 1'b0;
      endcase
      if (!w_sc_legal) begin
         w_sc_flags = 8'h80;
      end else if (op == OP_CMP) begin
         w_sc_flags = {5'b0, w_lt, w_gt, w_eq};
      end else begin
         w_sc_flags = f_flags(w_sc_result, w_sc_c, w_sc_v, w_sc_dz);
      end
   end

   // Shift-add multiply: r_hi accumulates, r_lo holds the multiplier and
   // fills with the low product half as it shifts right.
   logic [WIDTH-1:0] w_mul_addend;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH-1:0] w_mul_hi;
   logic [WIDTH-1:0] w_mul_lo;

   assign w_mul_addend = r_lo[0] ? r_opa : '0;
   assign w_mul_sum    = {1'b0, r_hi} + {1'b0, w_mul_addend};
   assign w_mul_hi     = w_mul_sum[WIDTH:1];
   assign w_mul_lo     = {w_mul_sum[0], r_lo[WIDTH-1:1]};

   // Restoring divide: r_hi is the partial remainder, r_lo shifts the
   // dividend out of the top and the quotient bits in at the bottom.
   logic [WIDTH:0]   w_div_shift;
   logic             w_div_ok;
   logic [WIDTH-1:0] w_div_diff;
   logic [WIDTH-1:0] w_div_hi;
   logic [WIDTH-1:0] w_div_lo;

   assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
   assign w_div_ok    = (w_div_shift >= {1'b0, r_opb});
   assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opb;
   assign w_div_hi    = w_div_ok ? w_div_diff : w_div_shift[WIDTH-1:0];
   assign w_div_lo    = {r_lo[WIDTH-2:0], w_div_ok};

   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b1;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         S_DONE: begin
            in_ready  = out_ready;
            out_valid = 1'b1;
         end
         default: ;
      endcase
      if (in_ready && in_valid) begin
         if (w_is_mul) begin
            w_next_state = S_MUL;
         end else if (w_is_div && !w_div_zero) begin
            w_next_state = S_DIV;
         end else begin
            w_next_state = S_DONE;
         end
      end else if (r_state == S_DONE && out_ready) begin
         w_next_state = S_IDLE;
      end else if ((r_state == S_MUL || r_state == S_DIV) && r_cnt == '0) begin
         w_next_state = S_DONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_op     <= '0;
         r_opa    <= '0;
         r_opb    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_rem    <= '0;
         r_flags  <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_op  <= op;
            r_opa <= a;
            r_opb <= b;
            r_cnt <= SHW'(WIDTH - 1);
            if (w_is_mul) begin
               r_hi <= '0;
               r_lo <= b;
            end else if (w_is_div && !w_div_zero) begin
               r_hi <= '0;
               r_lo <= a;
            end else begin
               r_result <= w_sc_result;
               r_rem    <= w_sc_rem;
               r_flags  <= w_sc_flags;
            end
         end else if (r_state == S_MUL) begin
            r_hi  <= w_mul_hi;
            r_lo  <= w_mul_lo;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
               r_result <= w_mul_lo;
               r_rem    <= w_mul_hi;
               r_flags  <= f_flags(w_mul_lo, |w_mul_hi, |w_mul_hi, 1'b0);
            end
         end else if (r_state == S_DIV) begin
            r_hi  <= w_div_hi;
            r_lo  <= w_div_lo;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
               r_result <= (r_op == OP_REM) ? w_div_hi : w_div_lo;
               r_rem    <= w_div_hi;
               r_flags  <= f_flags((r_op == OP_REM) ? w_div_hi : w_div_lo, 1'b0, 1'b0, 1'b0);
            end
         end
      end
   end

   assign result = r_result;
   assign rem    = r_rem;
   assign flags  = r_flags;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu: arithmetic reference model,
// randomized traffic with back-pressure, latency and output-hold checks.
module tb_seq_alu;
   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [W-1:0] rem;
   logic [7:0]   flags;
   logic         busy;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .rem(rem), .flags(flags), .busy(busy)
   );

   typedef struct {
      logic [7:0]   op;
      logic [W-1:0] res;
      logic [W-1:0] rem;
      logic [7:0]   flg;
      int           lat;
      int           acc_cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   ordy_rand = 0;
   bit   ordy_fixed = 1;

   logic [7:0] op_tbl [19] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                               8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h80,
                               8'h00, 8'h55, 8'hFF};

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic exp_t model(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t         e;
      longint       mask, ua, ub, r, rm, p;
      logic [W-1:0] rv;
      logic         c, v, dz, lt, gt, eq;
      int           amt;
      mask = (longint'(1) << W) - 1;
      ua = longint'(x);
      ub = longint'(y);
      r = 0; rm = 0; c = 0; v = 0; dz = 0;
      lt = ua < ub; gt = ua > ub; eq = ua == ub;
      amt = int'(ub % W);
      e.op = o;
      e.lat = 1;
      e.acc_cyc = 0;
      case (o)
         8'h01: begin
            r = ua + ub; c = ((r >> W) & 1) != 0; r = r & mask; rv = r[W-1:0];
            v = (x[W-1] == y[W-1]) && (rv[W-1] != x[W-1]);
         end
         8'h02: begin
            r = (ua - ub) & mask; c = ua < ub; rv = r[W-1:0];
            v = (x[W-1] != y[W-1]) && (rv[W-1] != x[W-1]);
         end
         8'h03: begin
            p = ua * ub; r = p & mask; rm = p >> W; c = rm != 0; v = c; e.lat = W + 1;
         end
         8'h04, 8'h05: begin
            if (ub == 0) begin
               dz = 1; r = mask; rm = ua;
            end else begin
               r = (o == 8'h04) ? ua / ub : ua % ub; rm = ua % ub; e.lat = W + 1;
            end
         end
         8'h06: r = ua & ub;
         8'h07: r = ua | ub;
         8'h08: r = ua ^ ub;
         8'h09: r = ~(ua & ub) & mask;
         8'h0A: r = ~(ua | ub) & mask;
         8'h0B: r = ~(ua ^ ub) & mask;
         8'h0C: r = ~ua & mask;
         8'h0D: begin
            if (amt == 0) r = ua;
            else begin r = (ua << amt) & mask; c = ((ua >> (W - amt)) & 1) != 0; end
         end
         8'h0E: begin
            if (amt == 0) r = ua;
            else begin r = ua >> amt; c = ((ua >> (amt - 1)) & 1) != 0; end
         end
         8'h0F: r = (lt ? 4 : 0) + (gt ? 2 : 0) + (eq ? 1 : 0);
         8'h80: r = ua;
         default: ;
      endcase
      rv = r[W-1:0];
      e.res = rv;
      e.rem = rm[W-1:0];
      if (o == 8'h0F) e.flg = {5'b0, lt, gt, eq};
      else if (!((o >= 8'h01 && o <= 8'h0F) || o == 8'h80)) e.flg = 8'h80;
      else e.flg = {1'b0, v, 1'b0, dz, ~^rv, rv[W-1], c, (rv == '0)};
      return e;
   endfunction

   // One cycle of stimulus; acc reports whether the request is taken at the coming edge.
   task automatic drive_cycle(input logic v, input logic [7:0] o, input logic [W-1:0] x,
                              input logic [W-1:0] y, output bit acc);
      exp_t e;
      @(negedge clk);
      out_ready = ordy_rand ? ($urandom_range(0, 3) != 0) : ordy_fixed;
      in_valid = v;
      op = o;
      a = x;
      b = y;
      #1;
      acc = v && in_ready;
      if (acc) begin
         e = model(o, x, y);
         e.acc_cyc = cyc;
         q.push_back(e);
      end
   endtask

   task automatic issue_n(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int n);
      bit acc;
      acc = 0;
      n = 0;
      while (!acc && n < 100) begin
         drive_cycle(1'b1, o, x, y, acc);
         n++;
      end
      if (!acc) begin
         checks++; errors++;
         $display("FAIL issue_timeout: op %0h not accepted within %0d cycles", o, n);
      end
   endtask

   task automatic issue(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int n;
      issue_n(o, x, y, n);
   endtask

   task automatic idle(input int n);
      bit d;
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00, '0, '0, d);
   endtask

   task automatic drain();
      int n;
      bit d;
      n = 0;
      ordy_rand = 0;
      ordy_fixed = 1;
      while ((q.size() != 0 || out_valid) && n < 400) begin
         drive_cycle(1'b0, 8'h00, '0, '0, d);
         n++;
      end
      if (n >= 400) begin
         checks++; errors++;
         $display("FAIL drain_timeout: %0d results still pending", q.size());
      end
   endtask

   // Monitor: latency, output hold under back-pressure, and scoreboard compare.
   bit           seen = 0;
   bit           hold = 0;
   logic [W-1:0] h_res;
   logic [W-1:0] h_rem;
   logic [7:0]   h_flg;

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (!rst_n) begin
         seen = 0;
         hold = 0;
      end else begin
         if (hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_result", result, h_res);
            check("hold_rem", rem, h_rem);
            check("hold_flags", flags, h_flg);
         end
         hold = 0;
         if (out_valid) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending result");
            end else begin
               if (!seen) begin
                  seen = 1;
                  check($sformatf("latency op=%0h", q[0].op), cyc - q[0].acc_cyc, q[0].lat);
               end
               if (out_ready) begin
                  e = q.pop_front();
                  seen = 0;
                  check($sformatf("result op=%0h", e.op), result, e.res);
                  check($sformatf("rem op=%0h", e.op), rem, e.rem);
                  check($sformatf("flags op=%0h", e.op), flags, e.flg);
               end else begin
                  hold = 1;
                  h_res = result;
                  h_rem = rem;
                  h_flg = flags;
               end
            end
         end
      end
   end

   initial begin
      int n;
      logic [7:0]   ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rst_n = 0; in_valid = 0; out_ready = 0; op = '0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("reset_out_valid", out_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_result", result, 0);
      check("reset_rem", rem, 0);
      check("reset_flags", flags, 0);
      #3 rst_n = 1;
      #1;
      check("post_reset_in_ready", in_ready, 1);

      ordy_fixed = 1;
      issue(8'h01, 8'h7F, 8'h01);
      issue(8'h03, 8'h10, 8'h20);
      issue(8'h04, 8'd200, 8'd7);
      issue(8'h04, 8'd200, 8'd0);
      issue(8'h05, 8'd200, 8'd7);
      issue(8'h05, 8'd13, 8'd0);
      issue(8'h03, 8'hFF, 8'hFF);
      issue(8'h0D, 8'h81, 8'd1);
      issue(8'h0D, 8'h5A, 8'd8);
      issue(8'h0E, 8'h81, 8'd3);
      issue(8'h0F, 8'd5, 8'd9);
      issue(8'h0F, 8'd9, 8'd9);
      issue(8'h55, 8'h12, 8'h34);
      issue(8'h80, 8'hA5, 8'h00);
      drain();

      ordy_fixed = 0;
      issue(8'h02, 8'd5, 8'd9);
      idle(5);
      check("bp_result", result, 8'hFC);
      check("bp_carry", flags[1], 1);
      check("bp_out_valid", out_valid, 1);
      ordy_fixed = 1;
      issue_n(8'h01, 8'd3, 8'd4, n);
      check("bp_same_cycle_accept", n, 1);
      drain();

      for (int i = 0; i < 400; i++) begin
         ordy_rand = 1;
         idle($urandom_range(0, 2));
         ro = op_tbl[$urandom_range(0, 18)];
         ra = W'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         issue(ro, ra, rb);
      end
      drain();

      issue(8'h03, 8'hFF, 8'hFF);
      idle(3);
      @(negedge clk);
      #3;
      check("mid_mul_busy", busy, 1);
      rst_n = 0;
      #1;
      check("rst_mid_out_valid", out_valid, 0);
      check("rst_mid_busy", busy, 0);
      q.delete();
      @(negedge clk);
      #3 rst_n = 1;
      #1;
      check("rel_in_ready", in_ready, 1);
      check("rel_busy", busy, 0);
      check("rel_out_valid", out_valid, 0);
      check("rel_result", result, 0);
      check("rel_rem", rem, 0);
      idle(12);
      issue(8'h01, 8'd1, 8'd2);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
